// File: rtl/mc_controller.sv
// mc_controller: multicycle control unit for the 32-bit ARM core.
//
// Decodes the latched instruction (IR) and sequences fetch, decode and execute.
// It drives the datapath mux selects, write enables, ALUControl and ImmSrc.
// It also holds the NZCV flag register and evaluates condition codes.
//
// Build option: define HALFWORD_IMM_EN to route the LDRH/STRH immediate
// encoding to the memory path with ImmSrc=11. Without it, that encoding
// decodes as a data-processing register op.
//
// Ports:
//   clk         in   1   core clock, rising edge
//   reset       in   1   asynchronous, active-high
//   Instr       in   32  IR contents: Cond[31:28] Op[27:26] Funct[25:20] Rd[15:12]
//   ALUFlags    in   4   {N,Z,C,V} from the ALU this cycle
//   PCWrite     out  1   PC load enable
//   MemWrite    out  1   data memory write enable
//   RegWrite    out  1   register file write enable
//   IRWrite     out  1   instruction register load enable
//   AdrSrc      out  1   0=PC, 1=ALU result as memory address
//   RegSrc      out  2   [0]=Op==10 (Rn<-R15), [1]=Op==01 (Rm<-Rd)
//   ALUSrcA     out  1   0=RD1, 1=PC
//   ALUSrcB     out  2   00=RD2 01=ExtImm 10=constant 4
//   ResultSrc   out  2   00=ALUOut 01=ReadData 10=ALUResult
//   ImmSrc      out  2   immediate extender format select
//   ALUControl  out  2   00 ADD, 01 SUB, 10 AND, 11 ORR
//
// States:
//   state  | meaning
//   FETCH  | read instruction at PC, load IR, PC+4
//   DECODE | read registers, choose execute path
//   MEMADR | compute memory address
//   MEMRD  | read data memory
//   MEMWB  | write loaded data to register file
//   MEMWR  | write data memory
//   EXECR  | ALU op on register operand, flags may update
//   EXECI  | ALU op on immediate operand, flags may update
//   ALUWB  | write ALU result to register file
//   BRANCH | load branch target into PC
module mc_controller #(
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  ALUControl
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  flags_q;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  cond;
    logic        is_hw;
    logic        ir_write, next_pc, reg_w, mem_w, branch, alu_op;
    logic        no_write, cond_ex, pcs;
    logic [1:0]  flag_w;
    logic        unused_bits;

    assign op    = Instr[27:26];
    assign funct = Instr[25:20];
    assign cond  = Instr[31:28];

`ifdef HALFWORD_IMM_EN
    assign is_hw = (op == 2'b00) & ~funct[5] & funct[2] & (Instr[7:4] == 4'b1011);
`else
    assign is_hw = 1'b0;
`endif

    assign unused_bits = ^{Instr[19:16], Instr[11:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = FETCH;
        ir_write  = 1'b0;
        next_pc   = 1'b0;
        reg_w     = 1'b0;
        mem_w     = 1'b0;
        branch    = 1'b0;
        alu_op    = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        case (state_q)
            FETCH: begin
                state_d   = DECODE;
                ir_write  = 1'b1;
                next_pc   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (op)
                    2'b01:   state_d = MEMADR;
                    2'b00:   state_d = is_hw ? MEMADR : (funct[5] ? EXECI : EXECR);
                    2'b10:   state_d = BRANCH;
                    default: state_d = FETCH;
                endcase
            end
            MEMADR: begin
                ALUSrcB = 2'b01;
                state_d = funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                AdrSrc  = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                reg_w     = 1'b1;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                mem_w  = 1'b1;
            end
            EXECR: begin
                alu_op  = 1'b1;
                state_d = ALUWB;
            end
            EXECI: begin
                ALUSrcB = 2'b01;
                alu_op  = 1'b1;
                state_d = ALUWB;
            end
            ALUWB: begin
                reg_w = 1'b1;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        ALUControl = 2'b00;
        if (alu_op) begin
            case (funct[4:1])
                4'b0100: ALUControl = 2'b00;
                4'b0010: ALUControl = 2'b01;
                4'b0000: ALUControl = 2'b10;
                4'b1100: ALUControl = 2'b11;
                4'b1010: ALUControl = 2'b01;
                default: ALUControl = 2'b00;
            endcase
        end
    end

    // Only ADD/SUB produce meaningful carry/overflow, so logical ops leave CV alone.
    assign flag_w = alu_op ? {funct[0], funct[0] & ~ALUControl[1]} : 2'b00;

    // CMP is recognised from Instr, not ALUOp, because the suppression lands in ALUWB.
    assign no_write = (op == 2'b00) & (funct[4:1] == 4'b1010);

    always_comb begin
        case (cond)
            4'b0000: cond_ex = flags_q[2];
            4'b0001: cond_ex = ~flags_q[2];
            4'b0010: cond_ex = flags_q[1];
            4'b0011: cond_ex = ~flags_q[1];
            4'b0100: cond_ex = flags_q[3];
            4'b0101: cond_ex = ~flags_q[3];
            4'b0110: cond_ex = flags_q[0];
            4'b0111: cond_ex = ~flags_q[0];
            4'b1000: cond_ex = flags_q[1] & ~flags_q[2];
            4'b1001: cond_ex = ~(flags_q[1] & ~flags_q[2]);
            4'b1010: cond_ex = (flags_q[3] == flags_q[0]);
            4'b1011: cond_ex = (flags_q[3] != flags_q[0]);
            4'b1100: cond_ex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
            4'b1101: cond_ex = ~(~flags_q[2] & (flags_q[3] == flags_q[0]));
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= FLAGS_RST;
        end else if (state_q == EXECR || state_q == EXECI) begin
            if (flag_w[1] & cond_ex) flags_q[3:2] <= ALUFlags[3:2];
            if (flag_w[0] & cond_ex) flags_q[1:0] <= ALUFlags[1:0];
        end
    end

    assign pcs = ((Instr[15:12] == 4'hF) & reg_w) | branch;

    assign PCWrite  = ~reset & (next_pc | (pcs & cond_ex));
    assign RegWrite = ~reset & reg_w & ~no_write & cond_ex;
    assign MemWrite = ~reset & mem_w & cond_ex;
    assign IRWrite  = ~reset & ir_write;

    assign RegSrc = {op == 2'b01, op == 2'b10};

    always_comb begin
        ImmSrc = (op == 2'b11) ? 2'b00 : op;
        if (is_hw && (state_q == MEMADR || state_q == MEMRD || state_q == MEMWR))
            ImmSrc = 2'b11;
    end

endmodule

// File: tb/tb_mc_controller.sv
module tb_mc_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
    logic [1:0]  RegSrc, ALUSrcB, ResultSrc, ImmSrc, ALUControl;

    always #5 clk = ~clk;

    mc_controller #(.FLAGS_RST(4'b0000)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .RegSrc(RegSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl)
    );

    // {PCWrite,MemWrite,RegWrite,IRWrite,AdrSrc,RegSrc,ALUSrcA,ALUSrcB,ResultSrc,ImmSrc,ALUControl}
    logic [15:0] obs;
    assign obs = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
                  ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl};

`ifdef HALFWORD_IMM_EN
    localparam bit HW_EN = 1'b1;
`else
    localparam bit HW_EN = 1'b0;
`endif

    int checks = 0;
    int failures = 0;
    logic [3:0] mflags;

    typedef enum int {P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR,
                      P_EXECR, P_EXECI, P_ALUWB, P_BRANCH} phase_t;
    phase_t plist[6];
    int     plen;

    // ARM conditions come in pairs: even code tests a predicate, odd code its inverse.
    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cf, v, r;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        if (c == 4'hF) return 1'b0;
        if (c == 4'hE) return 1'b1;
        case (c[3:1])
            3'd0: r = z;
            3'd1: r = cf;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cf && !z;
            3'd5: r = (n == v);
            default: r = !z && (n == v);
        endcase
        return c[0] ? !r : r;
    endfunction

    function automatic bit hw_instr(input logic [31:0] i);
        return HW_EN && i[27:26] == 2'b00 && !i[25] && i[22] && i[7:4] == 4'hB;
    endfunction

    function automatic logic [1:0] alu_fn(input logic [3:0] f4);
        if (f4 == 4'b0010 || f4 == 4'b1010) return 2'b01;
        if (f4 == 4'b0000) return 2'b10;
        if (f4 == 4'b1100) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [15:0] model_out(input phase_t ph, input logic [31:0] i,
                                              input logic [3:0] f);
        logic pcw, mw, rw, irw, adr, asa, ok, rd15, cmp;
        logic [1:0] asb, rs, imm, ac, rsrc, op;
        op   = i[27:26];
        ok   = cond_ok(i[31:28], f);
        rd15 = (i[15:12] == 4'hF);
        cmp  = (op == 2'b00) && (i[24:21] == 4'b1010);
        rsrc = {op == 2'b01, op == 2'b10};
        imm  = (op == 2'b11) ? 2'b00 : op;
        pcw = 0; mw = 0; rw = 0; irw = 0; adr = 0; asa = 0;
        asb = 2'b00; rs = 2'b00; ac = 2'b00;
        case (ph)
            P_FETCH:  begin irw = 1; pcw = 1; asa = 1; asb = 2'b10; rs = 2'b10; end
            P_DECODE: begin asa = 1; asb = 2'b10; rs = 2'b10; end
            P_MEMADR: begin asb = 2'b01; if (hw_instr(i)) imm = 2'b11; end
            P_MEMRD:  begin adr = 1; if (hw_instr(i)) imm = 2'b11; end
            P_MEMWR:  begin adr = 1; mw = ok; if (hw_instr(i)) imm = 2'b11; end
            P_MEMWB:  begin rs = 2'b01; rw = ok; pcw = rd15 && ok; end
            P_EXECR:  begin ac = alu_fn(i[24:21]); end
            P_EXECI:  begin asb = 2'b01; ac = alu_fn(i[24:21]); end
            P_ALUWB:  begin rw = ok && !cmp; pcw = rd15 && ok; end
            default:  begin asb = 2'b01; rs = 2'b10; pcw = ok; end
        endcase
        return {pcw, mw, rw, irw, adr, rsrc, asa, asb, rs, imm, ac};
    endfunction

    task automatic build_phases(input logic [31:0] i);
        plist[0] = P_FETCH;
        plist[1] = P_DECODE;
        plen = 2;
        if (i[27:26] == 2'b01 || hw_instr(i)) begin
            plist[2] = P_MEMADR;
            if (i[20]) begin plist[3] = P_MEMRD; plist[4] = P_MEMWB; plen = 5; end
            else       begin plist[3] = P_MEMWR; plen = 4; end
        end else if (i[27:26] == 2'b00) begin
            plist[2] = i[25] ? P_EXECI : P_EXECR;
            plist[3] = P_ALUWB;
            plen = 4;
        end else if (i[27:26] == 2'b10) begin
            plist[2] = P_BRANCH;
            plen = 3;
        end
    endtask

    task automatic cmp16(input string nm, input logic [31:0] i,
                         input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s instr=%08h got=%04h expected=%04h", nm, i, got, exp);
        end
    endtask

    task automatic step(input logic [31:0] i, input logic [3:0] af, input phase_t ph,
                        output logic [15:0] got);
        Instr = i;
        ALUFlags = af;
        #1;
        got = obs;
        cmp16(ph.name(), i, got, model_out(ph, i, mflags));
        if ((ph == P_EXECR || ph == P_EXECI) && i[20] && cond_ok(i[31:28], mflags)) begin
            mflags[3:2] = af[3:2];
            if (!(i[24:21] == 4'b0000 || i[24:21] == 4'b1100)) mflags[1:0] = af[1:0];
        end
        @(negedge clk);
    endtask

    task automatic run_instr(input logic [31:0] i, input logic [3:0] af,
                             output int len, output int pcw, output int rw, output int mw);
        logic [15:0] g;
        build_phases(i);
        len = 0; pcw = 0; rw = 0; mw = 0;
        for (int k = 0; k < plen; k++) begin
            step(i, af, plist[k], g);
            if (k == 0 || !g[12]) len++;
            pcw += int'(g[15]);
            mw  += int'(g[14]);
            rw  += int'(g[13]);
        end
        #1;
        checks++;
        if (IRWrite !== 1'b1) begin
            failures++;
            $display("FAIL ret_fetch instr=%08h IRWrite=%b expected=1", i, IRWrite);
        end
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  af;
        int          len;
        int          pcw;
        int          rw;
        int          mw;
    } vec_t;

    vec_t tbl[14];

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, pcw, rw, mw;
        logic [15:0] g;
        logic [31:0] r;

        tbl[0]  = '{32'hE2821005, 4'b0000, 4, 1, 1, 0};  // ADD R1,R2,#5
        tbl[1]  = '{32'hE0521003, 4'b0100, 4, 1, 1, 0};  // SUBS, Z=1
        tbl[2]  = '{32'h0A000002, 4'b0000, 3, 2, 0, 0};  // BEQ taken
        tbl[3]  = '{32'hE0521003, 4'b0000, 4, 1, 1, 0};  // SUBS, Z=0
        tbl[4]  = '{32'h0A000002, 4'b0000, 3, 1, 0, 0};  // BEQ not taken
        tbl[5]  = '{32'hE5910008, 4'b0000, 5, 1, 1, 0};  // LDR R0,[R1,#8]
        tbl[6]  = '{32'hE5810008, 4'b0000, 4, 1, 0, 1};  // STR R0,[R1,#8]
        tbl[7]  = '{32'hE1510002, 4'b0110, 4, 1, 0, 0};  // CMP, Z=1 C=1
        tbl[8]  = '{32'hF1510002, 4'b1001, 4, 1, 0, 0};  // CMP never
        tbl[9]  = '{32'h0A000002, 4'b0000, 3, 2, 0, 0};  // BEQ taken, flags kept
        tbl[10] = '{32'hEC000000, 4'b0000, 2, 1, 0, 0};  // Op=11 no-op
`ifdef HALFWORD_IMM_EN
        tbl[11] = '{32'hE1D102B4, 4'b0000, 5, 1, 1, 0};  // LDRH via memory path
        tbl[12] = '{32'h0A000002, 4'b0000, 3, 2, 0, 0};  // flags untouched by LDRH
`else
        tbl[11] = '{32'hE1D102B4, 4'b0000, 4, 1, 1, 0};  // decodes as EXECR, S=1
        tbl[12] = '{32'h0A000002, 4'b0000, 3, 1, 0, 0};  // Z cleared by that op
`endif
        tbl[13] = '{32'hE282F005, 4'b0000, 4, 2, 1, 0};  // ADD PC,R2,#5

        mflags   = 4'b0000;
        reset    = 1'b1;
        Instr    = 32'h0;
        ALUFlags = 4'h0;
        repeat (2) @(negedge clk);
        #1;
        cmp16("rst_init", Instr, obs, model_out(P_FETCH, Instr, mflags) & 16'h0FFF);
        Instr = 32'hE5910008;
        #1;
        cmp16("rst_init_ldr", Instr, obs, model_out(P_FETCH, Instr, mflags) & 16'h0FFF);
        reset = 1'b0;

        foreach (tbl[n]) begin
            run_instr(tbl[n].instr, tbl[n].af, len, pcw, rw, mw);
            checks++;
            if (len != tbl[n].len || pcw != tbl[n].pcw || rw != tbl[n].rw || mw != tbl[n].mw) begin
                failures++;
                $display("FAIL vec%0d instr=%08h len/pcw/rw/mw got=%0d/%0d/%0d/%0d expected=%0d/%0d/%0d/%0d",
                         n, tbl[n].instr, len, pcw, rw, mw, tbl[n].len, tbl[n].pcw, tbl[n].rw, tbl[n].mw);
            end
        end

        // Reset in the middle of a load, after Z has been set.
        run_instr(32'hE0521003, 4'b0100, len, pcw, rw, mw);
        step(32'hE5910008, 4'b0000, P_FETCH, g);
        step(32'hE5910008, 4'b0000, P_DECODE, g);
        step(32'hE5910008, 4'b0000, P_MEMADR, g);
        Instr = 32'hE5910008;
        #1;
        cmp16("memrd_pre_rst", Instr, obs, model_out(P_MEMRD, Instr, mflags));
        reset = 1'b1;
        #1;
        mflags = 4'b0000;
        cmp16("rst_memrd", Instr, obs, model_out(P_FETCH, Instr, mflags) & 16'h0FFF);
        @(negedge clk);
        #1;
        cmp16("rst_hold", Instr, obs, model_out(P_FETCH, Instr, mflags) & 16'h0FFF);
        reset = 1'b0;
        run_instr(32'h0A000002, 4'b0000, len, pcw, rw, mw);
        checks++;
        if (pcw != 1) begin
            failures++;
            $display("FAIL flags_rst BEQ PCWrite cycles got=%0d expected=1", pcw);
        end

        for (int n = 0; n < 400; n++) begin
            r = $urandom;
            if ($urandom_range(1, 0) == 1) r[31:28] = 4'hE;
            if ($urandom_range(7, 0) == 0) begin
                r[27:26] = 2'b00; r[25] = 1'b0; r[22] = 1'b1; r[7:4] = 4'hB;
            end
            run_instr(r, 4'($urandom), len, pcw, rw, mw);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
